// File: rtl/if_id_fetch_buffer.sv
// if_id_fetch_buffer
//   Fetch-side front end: issues one instruction-memory read per fetch,
//   captures the returned word into the IF/ID register (with a one-entry
//   skid buffer for ID stalls), pulses pc_en to let the PC advance, and
//   stops fetching after an HLT opcode until a flush redirects it.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   pc                    fetch address from the PC register
//   stall, flush          ID back-pressure / branch redirect squash
//   imem_req, imem_addr   one-cycle read request and its address
//   imem_valid, imem_data read response
//   pc_en                 one-cycle pulse: PC may load its next value
//   instr_ID, pc_ID,
//   pcInc_ID, valid_ID    IF/ID pipeline register
//   halted                HLT fetched, fetch stopped
module if_id_fetch_buffer #(
    parameter logic [15:0] NOP_INSTR = 16'h0000,
    parameter logic [3:0]  HALT_OPC  = 4'hF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] pc,
    input  logic        stall,
    input  logic        flush,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_valid,
    input  logic [15:0] imem_data,
    output logic        pc_en,
    output logic [15:0] instr_ID,
    output logic [15:0] pc_ID,
    output logic [15:0] pcInc_ID,
    output logic        valid_ID,
    output logic        halted
);

    typedef enum logic [1:0] {IDLE, WAIT, HOLD, HALTED} state_t;

    state_t      state, state_n;
    logic        drop, drop_n;
    logic [15:0] skid, skid_n;
    logic        req_n, en_n, vld_n, halted_n;
    logic [15:0] addr_n, instr_n, pcid_n, inc_n;
    logic        load;
    logic [15:0] ld_data;

    always_comb begin
        state_n  = state;
        drop_n   = drop;
        skid_n   = skid;
        req_n    = 1'b0;
        en_n     = 1'b0;
        addr_n   = imem_addr;   // holds the address of the outstanding fetch
        instr_n  = instr_ID;
        pcid_n   = pc_ID;
        inc_n    = pcInc_ID;
        vld_n    = valid_ID;
        halted_n = halted;
        load     = 1'b0;
        ld_data  = skid;

        // Bubble unless something is loaded below; a stall freezes IF/ID.
        if (flush || !stall) begin
            vld_n   = 1'b0;
            instr_n = NOP_INSTR;
        end

        case (state)
            IDLE: begin
                // A flush here may carry a stale pc; wait one cycle for the redirect.
                if (!flush) begin
                    req_n   = 1'b1;
                    addr_n  = pc;
                    state_n = WAIT;
                end
            end
            WAIT: begin
                if (flush) begin
                    if (imem_valid) begin
                        state_n = IDLE;
                        drop_n  = 1'b0;
                    end else begin
                        drop_n  = 1'b1;   // response still in flight; discard it on arrival
                    end
                end else if (imem_valid) begin
                    if (drop) begin
                        drop_n  = 1'b0;
                        state_n = IDLE;
                    end else if (!stall) begin
                        load    = 1'b1;
                        ld_data = imem_data;
                    end else begin
                        skid_n  = imem_data;
                        state_n = HOLD;
                    end
                end
            end
            HOLD: begin
                if (flush)       state_n = IDLE;
                else if (!stall) load    = 1'b1;
            end
            HALTED: begin
                if (flush) begin
                    state_n  = IDLE;
                    halted_n = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase

        if (load) begin
            instr_n = ld_data;
            pcid_n  = imem_addr;
            inc_n   = imem_addr + 16'h0002;
            vld_n   = 1'b1;
            en_n    = 1'b1;
            if (ld_data[15:12] == HALT_OPC) begin
                state_n  = HALTED;
                halted_n = 1'b1;
            end else begin
                state_n  = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            drop      <= 1'b0;
            skid      <= 16'h0000;
            imem_req  <= 1'b0;
            imem_addr <= 16'h0000;
            pc_en     <= 1'b0;
            instr_ID  <= NOP_INSTR;
            pc_ID     <= 16'h0000;
            pcInc_ID  <= 16'h0000;
            valid_ID  <= 1'b0;
            halted    <= 1'b0;
        end else begin
            state     <= state_n;
            drop      <= drop_n;
            skid      <= skid_n;
            imem_req  <= req_n;
            imem_addr <= addr_n;
            pc_en     <= en_n;
            instr_ID  <= instr_n;
            pc_ID     <= pcid_n;
            pcInc_ID  <= inc_n;
            valid_ID  <= vld_n;
            halted    <= halted_n;
        end
    end

endmodule

// File: tb/tb_if_id_fetch_buffer.sv
// Bench for if_id_fetch_buffer: directed scenarios, a transaction-level
// reference model compared every cycle, and literal spot checks.
module tb_if_id_fetch_buffer;

    localparam logic [15:0] NOP = 16'h0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] pc = 16'h0000;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_valid = 1'b0;
    logic [15:0] imem_data = 16'h0000;
    logic        pc_en;
    logic [15:0] instr_ID, pc_ID, pcInc_ID;
    logic        valid_ID, halted;

    int tests = 0;
    int fails = 0;
    int en_cnt = 0;
    int req_cnt = 0;
    int lat = 1;
    logic [15:0] mem [logic [15:0]];

    if_id_fetch_buffer dut (
        .clk(clk), .rst(rst), .pc(pc), .stall(stall), .flush(flush),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_data(imem_data),
        .pc_en(pc_en), .instr_ID(instr_ID), .pc_ID(pc_ID),
        .pcInc_ID(pcInc_ID), .valid_ID(valid_ID), .halted(halted)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_rd(input logic [15:0] a);
        if (mem.exists(a)) return mem[a];
        return {4'h1, a[11:0]};
    endfunction

    // Instruction memory: answers each request lat cycles later for one cycle.
    initial begin
        logic [15:0] a;
        forever begin
            @(negedge clk);
            if (imem_req === 1'b1) begin
                a = imem_addr;
                repeat (lat) @(posedge clk);
                #1 imem_valid = 1'b1; imem_data = mem_rd(a);
                @(posedge clk);
                #1 imem_valid = 1'b0; imem_data = 16'h0000;
            end
        end
    end

    // Reference model: tracks whether a fetch is outstanding, whether its
    // reply must be discarded, a parked instruction, and halt status.
    logic        m_out, m_drop, m_have, m_stop, started = 1'b0;
    logic [15:0] hd;
    logic        e_req, e_en, e_vld;
    logic [15:0] e_addr, e_instr, e_pc, e_inc;

    always @(posedge clk) begin
        logic idle, loaded;
        started = 1'b1;
        if (rst) begin
            m_out = 0; m_drop = 0; m_have = 0; m_stop = 0; hd = 0;
            e_req = 0; e_en = 0; e_vld = 0;
            e_addr = 0; e_instr = NOP; e_pc = 0; e_inc = 0;
        end else begin
            idle = !m_out && !m_have && !m_stop;
            loaded = 0; e_req = 0; e_en = 0;
            if (flush) begin
                if (m_out && !imem_valid) m_drop = 1;
                else begin m_out = 0; m_drop = 0; end
                m_have = 0; m_stop = 0;
            end else begin
                if (idle) begin
                    e_req = 1; e_addr = pc; m_out = 1;
                end else if (m_out && imem_valid) begin
                    m_out = 0;
                    if (m_drop) m_drop = 0;
                    else begin m_have = 1; hd = imem_data; end
                end
                if (m_have && !stall) begin
                    loaded = 1; m_have = 0; e_en = 1;
                    e_instr = hd; e_pc = e_addr; e_inc = e_addr + 16'd2; e_vld = 1;
                    m_stop = (hd[15:12] == 4'hF);
                end
            end
            if (!loaded && (flush || !stall)) begin e_vld = 0; e_instr = NOP; end
        end
    end

    always @(negedge clk) begin
        if (imem_req === 1'b1) req_cnt++;
        if (pc_en === 1'b1) en_cnt++;
        if (started) begin
            tests++;
            if (imem_req !== e_req || imem_addr !== e_addr || pc_en !== e_en ||
                instr_ID !== e_instr || pc_ID !== e_pc || pcInc_ID !== e_inc ||
                valid_ID !== e_vld || halted !== m_stop) begin
                fails++;
                $display("FAIL cycle_model t=%0t got req=%b addr=%h en=%b instr=%h pc=%h inc=%h vld=%b hlt=%b want req=%b addr=%h en=%b instr=%h pc=%h inc=%h vld=%b hlt=%b",
                    $time, imem_req, imem_addr, pc_en, instr_ID, pc_ID, pcInc_ID, valid_ID, halted,
                    e_req, e_addr, e_en, e_instr, e_pc, e_inc, e_vld, m_stop);
            end
        end
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    // One cycle; the PC register loads PC+2 when it sees pc_en.
    task automatic tick();
        @(posedge clk);
        #1;
        if (pc_en) pc = pc + 16'd2;
    endtask

    task automatic wait_en(input string nm);
        int n = 0;
        do begin tick(); n++; end while (!pc_en && n < 30);
        chk({nm, "_pc_en_seen"}, {15'd0, pc_en}, 16'd1);
    endtask

    task automatic wait_req(input string nm);
        int n = 0;
        do begin tick(); n++; end while (!imem_req && n < 30);
        chk({nm, "_req_seen"}, {15'd0, imem_req}, 16'd1);
    endtask

    task automatic do_reset(input logic [15:0] start_pc, input int l);
        rst = 1; stall = 0; flush = 0;
        repeat (8) tick();
        pc = start_pc; lat = l;
        rst = 0;
    endtask

    initial begin
        int e0, r0;
        mem[16'h0000] = 16'h1234;
        mem[16'h0010] = 16'h5A5A;
        mem[16'h0020] = 16'hBEEF;
        mem[16'h0040] = 16'hF000;

        // reset values
        repeat (3) tick();
        chk("rst_req", {15'd0, imem_req}, 16'd0);
        chk("rst_instr", instr_ID, NOP);
        chk("rst_valid", {15'd0, valid_ID}, 16'd0);
        chk("rst_halted", {15'd0, halted}, 16'd0);

        // basic fetch, latency 1
        do_reset(16'h0000, 1);
        e0 = en_cnt;
        wait_req("basic");
        chk("basic_addr", imem_addr, 16'h0000);
        wait_en("basic");
        chk("basic_instr", instr_ID, 16'h1234);
        chk("basic_pc", pc_ID, 16'h0000);
        chk("basic_inc", pcInc_ID, 16'h0002);
        chk("basic_valid", {15'd0, valid_ID}, 16'd1);
        wait_req("basic_next");
        chk("basic_next_addr", imem_addr, 16'h0002);
        chk("basic_one_en", en_cnt - e0, 1);

        // stall skid
        do_reset(16'h0010, 1);
        stall = 1;
        e0 = en_cnt; r0 = req_cnt;
        repeat (6) tick();
        chk("skid_no_en", en_cnt - e0, 0);
        chk("skid_one_req", req_cnt - r0, 1);
        chk("skid_valid_held", {15'd0, valid_ID}, 16'd0);
        stall = 0;
        wait_en("skid");
        chk("skid_instr", instr_ID, 16'h5A5A);
        chk("skid_pc", pc_ID, 16'h0010);
        chk("skid_valid", {15'd0, valid_ID}, 16'd1);

        // flush in WAIT, one cycle before the reply
        do_reset(16'h0020, 3);
        e0 = en_cnt;
        wait_req("flw");
        chk("flw_addr", imem_addr, 16'h0020);
        tick(); tick();
        flush = 1; pc = 16'h0100;
        tick();
        flush = 0;
        chk("flw_valid", {15'd0, valid_ID}, 16'd0);
        wait_req("flw_redirect");
        chk("flw_redirect_addr", imem_addr, 16'h0100);
        chk("flw_no_en", en_cnt - e0, 0);
        chk("flw_not_beef", {15'd0, instr_ID == 16'hBEEF}, 16'd0);

        // halt
        do_reset(16'h0040, 2);
        wait_en("hlt");
        chk("hlt_instr", instr_ID, 16'hF000);
        chk("hlt_halted", {15'd0, halted}, 16'd1);
        r0 = req_cnt;
        repeat (10) tick();
        chk("hlt_no_req", req_cnt - r0, 0);
        flush = 1; pc = 16'h0200;
        tick();
        flush = 0;
        chk("hlt_cleared", {15'd0, halted}, 16'd0);
        wait_req("hlt_resume");
        chk("hlt_resume_addr", imem_addr, 16'h0200);

        // wrap and bubble
        do_reset(16'hFFFE, 1);
        wait_en("wrap");
        chk("wrap_pc", pc_ID, 16'hFFFE);
        chk("wrap_inc", pcInc_ID, 16'h0000);
        tick();
        chk("bubble_valid", {15'd0, valid_ID}, 16'd0);
        chk("bubble_instr", instr_ID, NOP);
        chk("bubble_pc_hold", pc_ID, 16'hFFFE);

        // reset while a fetch is outstanding; the reply lands during reset
        do_reset(16'h0030, 4);
        wait_req("mid");
        tick();
        rst = 1;
        repeat (5) tick();
        chk("mid_req", {15'd0, imem_req}, 16'd0);
        chk("mid_valid", {15'd0, valid_ID}, 16'd0);
        chk("mid_instr", instr_ID, NOP);
        chk("mid_pcid", pc_ID, 16'h0000);
        chk("mid_addr", imem_addr, 16'h0000);
        rst = 0;
        wait_req("mid_fresh");
        chk("mid_fresh_addr", imem_addr, 16'h0030);
        repeat (10) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/if_id_fetch_buffer.md
Name: if_id_fetch_buffer

Overview:
- Consumes the fetch address produced by the PC logic and issues instruction-memory reads.
- Captures the returned instruction and drives the IF/ID pipeline register: instruction, PC and PC+2 to the ID stage.
- Returns a one-cycle pc_en pulse that permits the PC register to advance.
- Handles variable memory latency, ID-stage stalls (one-entry skid buffer), flushes from branch redirect, and HLT detection.

Parameters:
- NOP_INSTR, 16'h0000, instruction word driven on instr_ID when valid_ID=0
- HALT_OPC, 4'hF, opcode in instr[15:12] that halts fetch

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- pc  input  16  current PC register value (fetch address)
- stall  input  1  ID stage cannot accept a new instruction
- flush  input  1  squash IF/ID and in-flight fetch (branch redirect)
- imem_req  output  1  one-cycle read request pulse to instruction memory
- imem_addr  output  16  read address, valid when imem_req=1
- imem_valid  input  1  read data valid, at least 1 cycle after imem_req
- imem_data  input  16  instruction word, valid when imem_valid=1
- pc_en  output  1  one-cycle pulse: PC register may load next PC
- instr_ID  output  16  IF/ID instruction
- pc_ID  output  16  IF/ID PC of instr_ID
- pcInc_ID  output  16  IF/ID PC+2
- valid_ID  output  1  IF/ID holds a real instruction
- halted  output  1  HLT fetched; fetch stopped

Behaviour:
- Reset (rst=1 at posedge) forces the following values; rst has priority over all inputs, including mid-fetch, and a late imem_valid is ignored:
  - state=IDLE, drop=0, imem_req=0, imem_addr=0, pc_en=0
  - instr_ID=NOP_INSTR, pc_ID=0, pcInc_ID=0, valid_ID=0, halted=0
- States: IDLE, WAIT, HOLD, HALTED. All outputs are registered.
- IDLE:
  - Next cycle: imem_req=1, imem_addr=pc; go to WAIT.
  - The req pulse lasts exactly one cycle.
- WAIT:
  - Waits for imem_valid.
  - On imem_valid with drop=1: discard the data, clear drop, go to IDLE, no pc_en.
  - On imem_valid with stall=0 and flush=0:
    - Load instr_ID=imem_data, pc_ID=addr latched at request, pcInc_ID=addr+2, valid_ID=1.
    - Pulse pc_en.
    - Go to HALTED if imem_data[15:12]==HALT_OPC, else IDLE.
  - On imem_valid with stall=1: capture data and address into the skid buffer, go to HOLD, no pc_en.
- HOLD: when stall=0, move the skid buffer into IF/ID (same loading rules), pulse pc_en, go to HALTED or IDLE per opcode.
- HALTED:
  - halted=1, no further imem_req, pc_en=0.
  - IF/ID follows the normal stall/bubble rules.
- IF/ID when no new instruction is loaded:
  - stall=1: hold all IF/ID registers.
  - stall=0: valid_ID becomes 0 and instr_ID becomes NOP_INSTR (bubble); pc_ID and pcInc_ID hold.
- flush (priority over stall and over a same-cycle imem_valid):
  - Next cycle: valid_ID=0, instr_ID=NOP_INSTR.
  - WAIT without imem_valid this cycle: set drop=1, stay in WAIT.
  - WAIT with imem_valid this cycle: discard the data, go to IDLE.
  - HOLD: discard the buffer, go to IDLE.
  - HALTED: clear halted, go to IDLE; the halt was speculative.
  - No pc_en in the flush cycle. The next request uses the redirected pc.
- Arithmetic: pcInc_ID = address + 16'h0002 modulo 2^16 (16'hFFFE gives 16'h0000). No carry out.
- imem_valid outside WAIT is ignored.
- Max one outstanding request. Throughput: one instruction per (latency+2) cycles minimum.

Test Plan:
- Basic fetch:
  - Stimulus: reset, then pc=16'h0000, latency 1, imem_data=16'h1234.
  - Required: imem_req with addr 0; one cycle after imem_valid, instr_ID=16'h1234, pc_ID=0, pcInc_ID=2, valid_ID=1, with a single pc_en pulse.
  - Follow-up: next request uses pc=16'h0002.
- Stall skid:
  - Stimulus: stall=1 held across imem_valid with data 16'h5A5A at pc=16'h0010, for 3 cycles.
  - Required: IF/ID unchanged, no pc_en, no new req.
  - Then stall=0: instr_ID=16'h5A5A, pc_ID=16'h0010, valid_ID=1, pc_en pulse.
- Flush in WAIT:
  - Stimulus: req to 16'h0020, flush one cycle before imem_valid (data 16'hBEEF).
  - Required: data discarded, valid_ID=0, no pc_en; next req uses the redirected pc=16'h0100.
- Halt:
  - Stimulus: imem_data=16'hF000.
  - Required: instr_ID=16'hF000 loaded, halted=1, no further imem_req for 10 cycles.
  - Then flush=1: halted=0, fetch resumes.
- Wrap and bubble:
  - Stimulus: pc=16'hFFFE.
  - Required: pcInc_ID=16'h0000.
  - Follow-up: with stall=0 and no new data, the following cycle shows valid_ID=0, instr_ID=NOP_INSTR.
- Reset mid-operation:
  - Stimulus: rst asserted in WAIT, then imem_valid arrives.
  - Required: all outputs at reset values, response ignored, a fresh req issued after rst deasserts.
